// File: rtl/intra_pred_nxn.sv
// intra_pred_nxn: square NxN intra predictor (V, H, DC) streaming one row per beat.
// Neighbours are latched on an accepted start; DC is accumulated one index per cycle.
module intra_pred_nxn #(
  parameter int BIT_DEPTH = 8,
  parameter int MAX_N     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [1:0]                 size_sel,
  input  logic                       top_avail,
  input  logic                       left_avail,
  input  logic [MAX_N*BIT_DEPTH-1:0] top_pixels,
  input  logic [MAX_N*BIT_DEPTH-1:0] left_pixels,
  output logic                       busy,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [MAX_N*BIT_DEPTH-1:0] row_data,
  output logic [$clog2(MAX_N)-1:0]   row_idx,
  output logic                       row_last,
  output logic                       err
);
  localparam int IDX_W = $clog2(MAX_N);
  localparam int SUM_W = BIT_DEPTH + IDX_W + 1;
  localparam logic [1:0] MODE_V = 2'd0;
  localparam logic [1:0] MODE_H = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;
  localparam logic [BIT_DEPTH-1:0] DC_MID = {1'b1, {(BIT_DEPTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DCCALC, STREAM} state_t;
  state_t state_reg, state_next;

  logic [1:0]                 mode_reg;
  logic [2:0]                 lg_reg;      // log2 of the block edge
  logic                       top_av_reg;
  logic                       left_av_reg;
  logic [MAX_N*BIT_DEPTH-1:0] top_reg;
  logic [MAX_N*BIT_DEPTH-1:0] left_reg;
  logic [IDX_W-1:0]           cnt_reg;
  logic [SUM_W-1:0]           sum_reg;
  logic [BIT_DEPTH-1:0]       dc_reg;
  logic [IDX_W-1:0]           row_idx_reg;
  logic                       err_reg;

  logic                 accept, size_ok, req_err, beat;
  logic [IDX_W:0]       n_val, n_m1;
  logic [BIT_DEPTH-1:0] top_lane, left_lane, h_pix, dc_calc;

  assign n_val     = (IDX_W+1)'(1) << lg_reg;
  assign n_m1      = n_val - 1'b1;
  assign size_ok   = (size_sel != 2'd3) && ((int'(size_sel) + 2) <= IDX_W);
  assign req_err   = !size_ok || (mode == 2'd3) ||
                     (mode == MODE_V && !top_avail) || (mode == MODE_H && !left_avail);
  assign accept    = start && (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign row_valid = (state_reg == STREAM);
  assign beat      = row_valid && row_ready;
  assign row_idx   = row_idx_reg;
  assign row_last  = row_valid && ({1'b0, row_idx_reg} == n_m1);
  assign err       = err_reg;
  assign top_lane  = top_reg[cnt_reg*BIT_DEPTH +: BIT_DEPTH];
  assign left_lane = left_reg[cnt_reg*BIT_DEPTH +: BIT_DEPTH];
  assign h_pix     = left_reg[row_idx_reg*BIT_DEPTH +: BIT_DEPTH];

  // DC rounding: divide by the number of contributing samples, rounding half up.
  always_comb begin
    dc_calc = DC_MID;
    if (top_av_reg && left_av_reg)
      dc_calc = BIT_DEPTH'((sum_reg + SUM_W'(n_val)) >> (lg_reg + 3'd1));
    else if (top_av_reg || left_av_reg)
      dc_calc = BIT_DEPTH'((sum_reg + SUM_W'(n_val >> 1)) >> lg_reg);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !req_err) state_next = (mode == MODE_DC) ? ACC : STREAM;
      ACC:     if ({1'b0, cnt_reg} == n_m1) state_next = DCCALC;
      DCCALC:  state_next = STREAM;
      STREAM:  if (beat && row_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request capture, DC accumulation, row index and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg    <= '0;
      lg_reg      <= 3'd2;
      top_av_reg  <= 1'b0;
      left_av_reg <= 1'b0;
      top_reg     <= '0;
      left_reg    <= '0;
      cnt_reg     <= '0;
      sum_reg     <= '0;
      dc_reg      <= '0;
      row_idx_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= accept && req_err;
      case (state_reg)
        IDLE: begin
          if (accept && !req_err) begin
            mode_reg    <= mode;
            lg_reg      <= 3'(size_sel) + 3'd2;
            top_av_reg  <= top_avail;
            left_av_reg <= left_avail;
            top_reg     <= top_pixels;
            left_reg    <= left_pixels;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            row_idx_reg <= '0;
          end
        end
        ACC: begin
          sum_reg <= sum_reg + SUM_W'(top_av_reg ? top_lane : '0)
                             + SUM_W'(left_av_reg ? left_lane : '0);
          cnt_reg <= cnt_reg + 1'b1;
        end
        DCCALC: dc_reg <= dc_calc;
        STREAM: if (beat) row_idx_reg <= row_last ? '0 : row_idx_reg + 1'b1;
        default: ;
      endcase
    end
  end

  // Row lanes: lanes beyond the block edge and all lanes outside STREAM read zero.
  for (genvar gi = 0; gi < MAX_N; gi++) begin : g_lane
    logic [BIT_DEPTH-1:0] lane_pix;
    assign lane_pix = (mode_reg == MODE_V) ? top_reg[gi*BIT_DEPTH +: BIT_DEPTH] :
                      (mode_reg == MODE_H) ? h_pix : dc_reg;
    assign row_data[gi*BIT_DEPTH +: BIT_DEPTH] =
      (row_valid && ((IDX_W+1)'(gi) < n_val)) ? lane_pix : '0;
  end
endmodule

// File: tb/tb_intra_pred_nxn.sv
// tb_intra_pred_nxn: randomized self-checking bench with an arithmetic reference model.
module tb_intra_pred_nxn;
  localparam int BD = 8;
  localparam int MN = 16;
  localparam int DW = BD*MN;

  logic          clk = 1'b0;
  logic          reset, start, top_avail, left_avail, row_ready;
  logic [1:0]    mode, size_sel;
  logic [DW-1:0] top_pixels, left_pixels, row_data;
  logic          busy, row_valid, row_last, err;
  logic [3:0]    row_idx;

  always #5 clk = ~clk;

  intra_pred_nxn #(.BIT_DEPTH(BD), .MAX_N(MN)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .size_sel(size_sel),
    .top_avail(top_avail), .left_avail(left_avail),
    .top_pixels(top_pixels), .left_pixels(left_pixels),
    .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx), .row_last(row_last), .err(err)
  );

  int checks = 0;
  int failures = 0;

  int top_px[MN];
  int left_px[MN];
  int m_mode, m_size, m_n;
  bit m_ta, m_la;

  logic [DW-1:0] got_rows[$];
  int            got_idx[$];
  bit            got_last[$];
  int            first_lat, idle_lat, stall_bad, err_seen;
  bit            timed_out;

  function automatic bit model_err();
    return (m_mode == 3) || (m_size == 3) || (m_mode == 0 && !m_ta) || (m_mode == 1 && !m_la);
  endfunction

  // Expected row: V copies top, H repeats left[r], DC is the rounded mean of available samples.
  function automatic logic [DW-1:0] model_row(int r);
    logic [DW-1:0] v;
    int sum, cnt, dcv;
    v = '0; sum = 0; cnt = 0;
    for (int i = 0; i < m_n; i++) begin
      if (m_ta) begin sum += top_px[i]; cnt++; end
      if (m_la) begin sum += left_px[i]; cnt++; end
    end
    dcv = (cnt == 0) ? (1 << (BD-1)) : (sum + cnt/2) / cnt;
    for (int i = 0; i < m_n; i++)
      v[i*BD +: BD] = (m_mode == 0) ? BD'(top_px[i]) : (m_mode == 1) ? BD'(left_px[r]) : BD'(dcv);
    return v;
  endfunction

  function automatic int first_bad_row();
    for (int j = 0; j < got_rows.size(); j++)
      if (got_rows[j] !== model_row(j) || got_idx[j] != j || got_last[j] != (j == m_n-1))
        return j;
    return -1;
  endfunction

  task automatic rand_px();
    for (int i = 0; i < MN; i++) begin
      top_px[i]  = $urandom_range(0, 255);
      left_px[i] = $urandom_range(0, 255);
    end
  endtask

  // Issue one start (caller is 1 time unit after an edge); returns 1 unit after the accepting edge.
  task automatic do_start(input int md, input int sz, input bit ta, input bit la);
    m_mode = md; m_size = sz; m_ta = ta; m_la = la;
    m_n = (sz < 3) ? (4 << sz) : 0;
    for (int i = 0; i < MN; i++) begin
      top_pixels[i*BD +: BD]  = BD'(top_px[i]);
      left_pixels[i*BD +: BD] = BD'(left_px[i]);
    end
    mode = 2'(md); size_sel = 2'(sz); top_avail = ta; left_avail = la; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < MN; i++) begin
      top_pixels[i*BD +: BD]  = BD'($urandom);
      left_pixels[i*BD +: BD] = BD'($urandom);
    end
    top_avail = 1'($urandom); left_avail = 1'($urandom);
  endtask

  // Consume rows until busy drops; pat 0 = ready high, 1 = toggling, 2 = random.
  task automatic collect(input int pat);
    int cyc, pi;
    bit prev_stall, pl, rdy, tog;
    logic [DW-1:0] pd;
    got_rows.delete(); got_idx.delete(); got_last.delete();
    first_lat = -1; idle_lat = -1; stall_bad = 0; err_seen = 0; timed_out = 0;
    cyc = 1; prev_stall = 0; tog = 1; pd = '0; pi = 0; pl = 0;
    while (1) begin
      if (err) err_seen++;
      rdy = (pat == 0) ? 1'b1 : (pat == 1) ? tog : 1'($urandom_range(0, 1));
      if (row_valid) begin
        if (first_lat < 0) first_lat = cyc;
        if (prev_stall && (row_data !== pd || int'(row_idx) != pi || row_last !== pl)) stall_bad++;
        if (rdy) begin
          got_rows.push_back(row_data); got_idx.push_back(int'(row_idx)); got_last.push_back(row_last);
        end
        prev_stall = !rdy; pd = row_data; pi = int'(row_idx); pl = row_last;
      end else begin
        if (prev_stall) stall_bad++;
        prev_stall = 0;
      end
      tog = !tog;
      row_ready = rdy;
      if (!busy) begin idle_lat = cyc; break; end
      if (cyc >= 300) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    row_ready = 1'b0;
    $display("txn mode=%0d size=%0d top_av=%0d left_av=%0d rows=%0d err=%0d first=%0d idle=%0d",
             m_mode, m_size, m_ta, m_la, got_rows.size(), err_seen, first_lat, idle_lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = '0; size_sel = '0; top_avail = 1'b0; left_avail = 1'b0;
    top_pixels = '0; left_pixels = '0; row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (row_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", row_valid); end
    checks++; if (row_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", row_data); end
    checks++; if (row_idx !== '0 || row_last !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_misc idx=%0d last=%b err=%b want=0,0,0", row_idx, row_last, err);
    end
    reset = 1'b0;
  endtask

  task automatic test_v4();
    int bad;
    logic [DW-1:0] exp;
    rand_px();
    top_px[0] = 10; top_px[1] = 20; top_px[2] = 30; top_px[3] = 40;
    exp = '0; exp[31:0] = {8'd40, 8'd30, 8'd20, 8'd10};
    do_start(0, 0, 1, 0);
    collect(0);
    checks++; if (timed_out || got_rows.size() != 4) begin failures++; $display("FAIL v4_count got=%0d want=4 timeout=%0d", got_rows.size(), timed_out); end
    checks++; bad = first_bad_row(); if (bad >= 0) begin failures++; $display("FAIL v4_rows row=%0d got=%h want=%h", bad, got_rows[bad], model_row(bad)); end
    checks++; if (got_rows.size() < 4 || got_rows[3] !== exp) begin failures++; $display("FAIL v4_row3 got=%h want=%h", got_rows[3], exp); end
    checks++; if (first_lat != 1) begin failures++; $display("FAIL v4_first_lat got=%0d want=1", first_lat); end
    checks++; if (idle_lat != 5) begin failures++; $display("FAIL v4_idle_lat got=%0d want=5", idle_lat); end
  endtask

  task automatic test_h8_stall();
    int bad;
    rand_px();
    for (int j = 0; j < 8; j++) left_px[j] = j + 1;
    do_start(1, 1, 0, 1);
    collect(1);
    checks++; if (timed_out || got_rows.size() != 8) begin failures++; $display("FAIL h8_count got=%0d want=8 timeout=%0d", got_rows.size(), timed_out); end
    checks++; bad = first_bad_row(); if (bad >= 0) begin failures++; $display("FAIL h8_rows row=%0d got=%h want=%h", bad, got_rows[bad], model_row(bad)); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL h8_stall_hold got=%0d want=0", stall_bad); end
    checks++; if (err_seen != 0) begin failures++; $display("FAIL h8_err got=%0d want=0", err_seen); end
  endtask

  task automatic test_dc16();
    int bad;
    for (int i = 0; i < MN; i++) begin top_px[i] = 100; left_px[i] = 101; end
    do_start(2, 2, 1, 1);
    collect(0);
    checks++; if (timed_out || got_rows.size() != 16) begin failures++; $display("FAIL dc16_count got=%0d want=16 timeout=%0d", got_rows.size(), timed_out); end
    checks++; bad = first_bad_row(); if (bad >= 0) begin failures++; $display("FAIL dc16_rows row=%0d got=%h want=%h", bad, got_rows[bad], model_row(bad)); end
    checks++; if (got_rows.size() < 1 || got_rows[0][127:120] !== 8'd101 || got_rows[0][7:0] !== 8'd101) begin
      failures++; $display("FAIL dc16_value got=%0d want=101", got_rows[0][7:0]);
    end
    checks++; if (first_lat != 18) begin failures++; $display("FAIL dc16_first_lat got=%0d want=18", first_lat); end
    checks++; if (idle_lat != 34) begin failures++; $display("FAIL dc16_idle_lat got=%0d want=34", idle_lat); end
  endtask

  task automatic test_dc_avail();
    int bad;
    // Top only, 4x4.
    rand_px();
    for (int i = 0; i < 4; i++) top_px[i] = i + 1;
    do_start(2, 0, 1, 0);
    collect(2);
    checks++; bad = first_bad_row(); if (bad >= 0 || got_rows.size() != 4) begin failures++; $display("FAIL dc_top_rows row=%0d count=%0d want 4 matching rows", bad, got_rows.size()); end
    checks++; if (got_rows.size() < 1 || got_rows[0][7:0] !== 8'd3) begin failures++; $display("FAIL dc_top_value got=%0d want=3", got_rows[0][7:0]); end
    // No neighbours, 8x8.
    rand_px();
    do_start(2, 1, 0, 0);
    collect(2);
    checks++; bad = first_bad_row(); if (bad >= 0 || got_rows.size() != 8) begin failures++; $display("FAIL dc_none_rows row=%0d count=%0d want 8 matching rows", bad, got_rows.size()); end
    checks++; if (got_rows.size() < 1 || got_rows[0][63:56] !== 8'd128) begin failures++; $display("FAIL dc_none_value got=%0d want=128", got_rows[0][63:56]); end
    // Left only, all 255, 16x16.
    rand_px();
    for (int i = 0; i < MN; i++) left_px[i] = 255;
    do_start(2, 2, 0, 1);
    collect(2);
    checks++; bad = first_bad_row(); if (bad >= 0 || got_rows.size() != 16) begin failures++; $display("FAIL dc_left_rows row=%0d count=%0d want 16 matching rows", bad, got_rows.size()); end
    checks++; if (got_rows.size() < 16 || got_rows[15][127:120] !== 8'd255) begin failures++; $display("FAIL dc_left_value got=%0d want=255", got_rows[15][127:120]); end
  endtask

  task automatic test_errors();
    int cases[4][4] = '{'{0, 0, 0, 1}, '{1, 1, 1, 0}, '{3, 0, 1, 1}, '{0, 3, 1, 1}};
    int extra;
    for (int k = 0; k < 4; k++) begin
      rand_px();
      do_start(cases[k][0], cases[k][1], 1'(cases[k][2]), 1'(cases[k][3]));
      collect(0);
      checks++; if (err_seen != 1) begin failures++; $display("FAIL err%0d_pulse got=%0d want=1", k, err_seen); end
      checks++; if (got_rows.size() != 0 || first_lat >= 0 || idle_lat != 1) begin
        failures++; $display("FAIL err%0d_no_rows rows=%0d first=%0d idle=%0d want 0,-1,1", k, got_rows.size(), first_lat, idle_lat);
      end
      extra = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (err || row_valid || busy) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL err%0d_quiet got=%0d want=0", k, extra); end
    end
  endtask

  task automatic test_busy_ignore();
    int bad;
    rand_px();
    do_start(2, 1, 1, 1);
    @(posedge clk); #1;
    mode = 2'd0; size_sel = 2'd0; top_avail = 1'b1; left_avail = 1'b1; start = 1'b1;
    for (int i = 0; i < MN; i++) top_pixels[i*BD +: BD] = BD'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    collect(2);
    checks++; if (timed_out || got_rows.size() != 8) begin failures++; $display("FAIL busy_count got=%0d want=8", got_rows.size()); end
    checks++; bad = first_bad_row(); if (bad >= 0) begin failures++; $display("FAIL busy_rows row=%0d got=%h want=%h", bad, got_rows[bad], model_row(bad)); end
    checks++; if (err_seen != 0) begin failures++; $display("FAIL busy_err got=%0d want=0", err_seen); end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int phase = 0; phase < 2; phase++) begin
      rand_px();
      if (phase == 0) do_start(2, 2, 1, 1);
      else            do_start(0, 2, 1, 1);
      row_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1 || row_valid !== 1'(phase)) begin
        failures++; $display("FAIL rstmid%0d_pre busy=%b valid=%b want 1,%0d", phase, busy, row_valid, phase);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || row_valid !== 1'b0 || row_data !== '0 || row_idx !== '0 || row_last !== 1'b0 || err !== 1'b0) begin
        failures++; $display("FAIL rstmid%0d_state busy=%b valid=%b data=%h idx=%0d last=%b err=%b want all 0",
                             phase, busy, row_valid, row_data, row_idx, row_last, err);
      end
      reset = 1'b0;
    end
    rand_px();
    do_start(0, 1, 1, 0);
    collect(2);
    checks++; bad = first_bad_row(); if (bad >= 0 || got_rows.size() != 8 || err_seen != 0) begin
      failures++; $display("FAIL rstmid_after row=%0d count=%0d err=%0d want -1,8,0", bad, got_rows.size(), err_seen);
    end
  endtask

  task automatic test_random();
    int bad, want_n;
    bit want_err;
    for (int t = 0; t < 24; t++) begin
      rand_px();
      do_start($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      collect(2);
      want_err = model_err();
      want_n = want_err ? 0 : m_n;
      checks++; if (err_seen != int'(want_err) || got_rows.size() != want_n || timed_out) begin
        failures++; $display("FAIL rand%0d_shape err=%0d rows=%0d want err=%0d rows=%0d", t, err_seen, got_rows.size(), want_err, want_n);
      end
      checks++; bad = first_bad_row(); if (bad >= 0) begin failures++; $display("FAIL rand%0d_rows row=%0d got=%h want=%h", t, bad, got_rows[bad], model_row(bad)); end
      checks++; if (stall_bad != 0) begin failures++; $display("FAIL rand%0d_stall got=%0d want=0", t, stall_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_v4();
    test_h8_stall();
    test_dc16();
    test_dc_avail();
    test_errors();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
